// File: rtl/user_pkg.sv
// Shared OBI request/response types and arbiter sizing constants.
// Imported by cnn_mem_arbiter and cnn_arb_id_fifo.
package user_pkg;

    localparam int unsigned CnnArbNumReq   = 2;
    localparam int unsigned CnnArbMaxTrans = 2;

    localparam int unsigned ObiAddrW = 32;
    localparam int unsigned ObiDataW = 32;

    typedef struct packed {
        logic                  req;
        logic [ObiAddrW-1:0]   addr;
        logic                  we;
        logic [ObiDataW/8-1:0] be;
        logic [ObiDataW-1:0]   wdata;
    } mgr_obi_req_t;

    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        logic [ObiDataW-1:0] rdata;
        logic                err;
    } mgr_obi_rsp_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_arb_id_fifo.sv
// In-order FIFO of granted requester indices; a pop frees its slot for a
// push in the same cycle, so a full FIFO can accept while draining.
module cnn_arb_id_fifo
    import user_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned IdW   = 1,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic [IdW-1:0]  push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [IdW-1:0]  head,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [IdW-1:0]  mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            push_eff;
    logic            pop_eff;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full     = (count == CntW'(Depth));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_eff) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({push_eff, pop_eff})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cnn_mem_arbiter.sv
// Round-robin OBI arbiter sharing one manager port among NumReq requesters.
// Optional per-requester stall counters when CNN_ARB_STALL_CNT_EN is defined.
module cnn_mem_arbiter
    import user_pkg::*;
#(
    parameter int unsigned NumReq   = CnnArbNumReq,
    parameter int unsigned MaxTrans = CnnArbMaxTrans
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  mgr_obi_req_t [NumReq-1:0] req_i,
    output mgr_obi_rsp_t [NumReq-1:0] rsp_o,
    output mgr_obi_req_t              mgr_req_o,
    input  mgr_obi_rsp_t              mgr_rsp_i,
    output logic                      busy_o
`ifdef CNN_ARB_STALL_CNT_EN
    ,
    output logic [NumReq-1:0][15:0]   stall_cnt_o
`endif
);

    localparam int unsigned IdW  = idx_width(NumReq);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic [IdW-1:0]  last_q;
    logic [IdW-1:0]  lock_idx_q;
    logic            lock_q;
    logic [IdW-1:0]  rr_idx;
    logic [IdW-1:0]  cand_idx;
    logic            rr_found;
    int unsigned     cand;
    logic [IdW-1:0]  sel_idx;
    logic            sel_valid;
    logic            issue_ok;
    logic            hs;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdW-1:0]  fifo_head;
    logic [CntW-1:0] fifo_count;

    always_comb begin
        rr_idx   = last_q;
        rr_found = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand     = (32'(last_q) + k) % NumReq;
            cand_idx = IdW'(cand);
            if (!rr_found && req_i[cand_idx].req) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // A presented-but-ungranted request pins the selection so its payload
    // stays stable, including while the ID FIFO is full.
    assign sel_idx   = lock_q ? lock_idx_q : rr_idx;
    assign sel_valid = req_i[sel_idx].req;
    assign pop       = mgr_rsp_i.rvalid && !fifo_empty && !rst_i;
    assign issue_ok  = !fifo_full || pop;

    always_comb begin
        mgr_req_o     = req_i[sel_idx];
        mgr_req_o.req = sel_valid && issue_ok && !rst_i;
    end

    assign hs     = mgr_req_o.req && mgr_rsp_i.gnt;
    assign busy_o = (fifo_count != '0) && !rst_i;

    always_comb begin
        rsp_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            rsp_o[i].gnt = hs && (sel_idx == IdW'(i));
            if (pop && (fifo_head == IdW'(i))) begin
                rsp_o[i].rvalid = 1'b1;
                rsp_o[i].rdata  = mgr_rsp_i.rdata;
                rsp_o[i].err    = mgr_rsp_i.err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= IdW'(NumReq - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (hs) begin
                last_q <= sel_idx;
            end
            lock_q     <= sel_valid && !hs;
            lock_idx_q <= sel_idx;
        end
    end

    cnn_arb_id_fifo #(
        .Depth (MaxTrans),
        .IdW   (IdW),
        .CntW  (CntW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (hs),
        .push_id (sel_idx),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

`ifdef CNN_ARB_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else begin
            for (int i = 0; i < int'(NumReq); i++) begin
                if (req_i[i].req && !rsp_o[i].gnt && (stall_cnt_o[i] != 16'hFFFF)) begin
                    stall_cnt_o[i] <= stall_cnt_o[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// Directed self-checking bench for cnn_mem_arbiter (NumReq=2, MaxTrans=2).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_cnn_mem_arbiter;
    import user_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    mgr_obi_req_t [1:0] req;
    mgr_obi_rsp_t [1:0] rsp;
    mgr_obi_req_t       mreq;
    mgr_obi_rsp_t       mrsp;
    logic               busy;
`ifdef CNN_ARB_STALL_CNT_EN
    logic [1:0][15:0]   stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cnn_mem_arbiter #(
        .NumReq   (2),
        .MaxTrans (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .rsp_o       (rsp),
        .mgr_req_o   (mreq),
        .mgr_rsp_i   (mrsp),
        .busy_o      (busy)
`ifdef CNN_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    function automatic logic [1:0] gvec();
        return {rsp[1].gnt, rsp[0].gnt};
    endfunction

    function automatic logic [1:0] rvec();
        return {rsp[1].rvalid, rsp[0].rvalid};
    endfunction

    task automatic idle();
        req  = '0;
        mrsp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req[0].req  = 1'b1;
        req[0].addr = 32'h40;
        mrsp.gnt    = 1'b1;
        mrsp.rvalid = 1'b1;
        #1;
        n_cmp++; if (mreq.req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mreq.req); end
        n_cmp++; if (gvec() !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gvec()); end
        n_cmp++; if (rvec() !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", rvec()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [5];
        logic [1:0] exp_r [5];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        exp_r = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req[0].req   = (c < 4);
            req[0].addr  = 32'h100;
            req[1].req   = (c < 4);
            req[1].addr  = 32'h200;
            mrsp.gnt     = 1'b1;
            mrsp.rvalid  = (c >= 1);
            mrsp.rdata   = 32'h1000 + 32'(c);
            #1;
            n_cmp++; if (gvec() !== exp_g[c]) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gvec(), exp_g[c]); end
            if (exp_g[c] != 2'b00) begin
                n_cmp++;
                if (mreq.addr !== (exp_g[c][1] ? 32'h200 : 32'h100)) begin
                    n_bad++; $display("FAIL rr_addr[%0d]: got %h", c, mreq.addr);
                end
            end else begin
                n_cmp++; if (mreq.req !== 1'b0) begin n_bad++; $display("FAIL rr_noreq[%0d]: got %b want 0", c, mreq.req); end
            end
            n_cmp++; if (rvec() !== exp_r[c]) begin n_bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, rvec(), exp_r[c]); end
            if (exp_r[c] != 2'b00) begin
                n_cmp++;
                if (rsp[exp_r[c][1]].rdata !== 32'h1000 + 32'(c)) begin
                    n_bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", c, rsp[exp_r[c][1]].rdata, 32'h1000 + 32'(c));
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req[0].req  = 1'b1;
            req[0].addr = 32'hA0;
            req[1].req  = (c >= 1);
            req[1].addr = 32'hB0;
            mrsp.gnt    = (c == 3);
            #1;
            n_cmp++; if (mreq.req !== 1'b1 || mreq.addr !== 32'hA0) begin n_bad++; $display("FAIL lock_addr[%0d]: got req=%b addr=%h want 1/a0", c, mreq.req, mreq.addr); end
            n_cmp++; if (gvec() !== ((c == 3) ? 2'b01 : 2'b00)) begin n_bad++; $display("FAIL lock_gnt[%0d]: got %b", c, gvec()); end
            @(negedge clk);
        end
        req[0].req = 1'b0;
        mrsp.gnt   = 1'b1;
        #1;
        n_cmp++; if (mreq.addr !== 32'hB0 || gvec() !== 2'b10) begin n_bad++; $display("FAIL lock_next: got addr=%h gnt=%b want b0/10", mreq.addr, gvec()); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_fifo_full();
        do_reset();
        req[0].req  = 1'b1;
        req[0].addr = 32'hC0;
        mrsp.gnt    = 1'b1;
        #1;
        n_cmp++; if (gvec() !== 2'b01) begin n_bad++; $display("FAIL full_g0: got %b want 01", gvec()); end
        @(negedge clk); #1;
        n_cmp++; if (gvec() !== 2'b01) begin n_bad++; $display("FAIL full_b2b: got %b want 01", gvec()); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy1: got %b want 1", busy); end
        @(negedge clk); #1;
        n_cmp++; if (mreq.req !== 1'b0 || gvec() !== 2'b00) begin n_bad++; $display("FAIL full_hold: got req=%b gnt=%b want 0/00", mreq.req, gvec()); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy2: got %b want 1", busy); end
        @(negedge clk);
        mrsp.rvalid = 1'b1;
        mrsp.rdata  = 32'h11;
        #1;
        n_cmp++; if (mreq.req !== 1'b1 || gvec() !== 2'b01) begin n_bad++; $display("FAIL full_third: got req=%b gnt=%b want 1/01", mreq.req, gvec()); end
        n_cmp++; if (rvec() !== 2'b01 || rsp[0].rdata !== 32'h11) begin n_bad++; $display("FAIL full_rsp1: got rv=%b rdata=%h", rvec(), rsp[0].rdata); end
        @(negedge clk);
        req[0].req = 1'b0;
        mrsp.rdata = 32'h22;
        #1;
        n_cmp++; if (rvec() !== 2'b01 || rsp[0].rdata !== 32'h22) begin n_bad++; $display("FAIL full_rsp2: got rv=%b rdata=%h", rvec(), rsp[0].rdata); end
        @(negedge clk);
        mrsp.rdata = 32'h33;
        #1;
        n_cmp++; if (rvec() !== 2'b01 || rsp[0].rdata !== 32'h33) begin n_bad++; $display("FAIL full_rsp3: got rv=%b rdata=%h", rvec(), rsp[0].rdata); end
        @(negedge clk);
        mrsp.rvalid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_drained: got busy=%b want 0", busy); end
        idle();
    endtask

    task automatic test_empty_rvalid();
        do_reset();
        mrsp.rvalid = 1'b1;
        mrsp.rdata  = 32'hDEADBEEF;
        #1;
        n_cmp++; if (rvec() !== 2'b00) begin n_bad++; $display("FAIL empty_rv0: got %b want 00", rvec()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy: got %b want 0", busy); end
        @(negedge clk); #1;
        n_cmp++; if (rvec() !== 2'b00) begin n_bad++; $display("FAIL empty_rv1: got %b want 00", rvec()); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req[0].req  = 1'b1;
        req[0].addr = 32'hD0;
        mrsp.gnt    = 1'b1;
        #1;
        n_cmp++; if (gvec() !== 2'b01) begin n_bad++; $display("FAIL mid_g0: got %b want 01", gvec()); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_clr: got %b want 0", busy); end
        mrsp.rvalid = 1'b1;
        mrsp.rdata  = 32'h55;
        #1;
        n_cmp++; if (rvec() !== 2'b00) begin n_bad++; $display("FAIL mid_stale_rv: got %b want 00", rvec()); end
        @(negedge clk);
        idle();
        req[0].req  = 1'b1;
        req[0].addr = 32'hE0;
        req[1].req  = 1'b1;
        req[1].addr = 32'hE4;
        mrsp.gnt    = 1'b1;
        #1;
        n_cmp++; if (gvec() !== 2'b01 || mreq.addr !== 32'hE0) begin n_bad++; $display("FAIL mid_first_idx0: got gnt=%b addr=%h want 01/e0", gvec(), mreq.addr); end
        @(negedge clk);
        idle();
    endtask

`ifdef CNN_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req[1].req  = 1'b1;
            req[1].addr = 32'hF0;
            mrsp.gnt    = 1'b0;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (stall_cnt[1] !== 16'd5) begin n_bad++; $display("FAIL stall_cnt1: got %0d want 5", stall_cnt[1]); end
        n_cmp++; if (stall_cnt[0] !== 16'd0) begin n_bad++; $display("FAIL stall_cnt0: got %0d want 0", stall_cnt[0]); end
        idle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_empty_rvalid();
        test_reset_mid();
`ifdef CNN_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
